// File: rtl/ps2_rx_ctrl_if.sv
// Valid/ready hand-off of received PS/2 scan codes plus frame status flags.
`timescale 1ns/1ps
interface ps2_rx_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overflow;
  logic       busy;

  modport master (
    output rx_data, rx_valid, frame_err, overflow, busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, overflow, busy,
    output rx_ready
  );
endinterface

// File: rtl/ps2_rx_ctrl.sv
// PS/2 keyboard frame receiver: synchronise, deframe, validate, hand off over valid/ready.
// Optional break-code filtering is enabled by defining PS2_BREAK_FILTER_EN.
`timescale 1ns/1ps
module ps2_rx_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 25000
) (
  input  logic          Clk,
  input  logic          nReset,
  input  logic          ps2_nclk,
  input  logic          ndata,
  ps2_rx_ctrl_if.master rx
);

  localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   sync_clk_q;
  logic                   sync_clk, sync_dat, fall;

  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            par_ok_q, par_ok_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            frame_err_q, frame_err_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            overflow_q, overflow_d;
  logic            done, present, accept;

  assign sync_clk = clk_sync_q[SYNC_STAGES-1];
  assign sync_dat = dat_sync_q[SYNC_STAGES-1];
  assign fall     = sync_clk_q & ~sync_clk;

  // Synchronisers idle high so no spurious fall is seen out of reset.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      sync_clk_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_nclk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ndata};
      sync_clk_q <= sync_clk;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    par_ok_d    = par_ok_q;
    frame_err_d = 1'b0;
    done        = 1'b0;
    if (state_q == StIdle || fall) tmo_cnt_d = '0;
    else                           tmo_cnt_d = tmo_cnt_q + 1'b1;

    if (state_q != StIdle && !fall && tmo_cnt_q == TmoMax) begin
      frame_err_d = 1'b1;
      state_d     = StIdle;
      shreg_d     = '0;
      tmo_cnt_d   = '0;
    end else if (fall) begin
      unique case (state_q)
        StIdle: begin
          // A high level on a fall is a glitch, not a start bit.
          if (!sync_dat) begin
            state_d   = StData;
            bit_cnt_d = 3'd0;
          end
        end
        StData: begin
          shreg_d[bit_cnt_q] = sync_dat;
          if (bit_cnt_q == 3'd7) state_d = StParity;
          else                   bit_cnt_d = bit_cnt_q + 3'd1;
        end
        StParity: begin
          par_ok_d = ^{shreg_q, sync_dat};
          state_d  = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (sync_dat && par_ok_q) done = 1'b1;
          else                      frame_err_d = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

`ifdef PS2_BREAK_FILTER_EN
  logic break_pend_q, break_pend_d;

  // F0 arms the filter; the following byte (the released key) is swallowed.
  always_comb begin
    break_pend_d = break_pend_q;
    present      = 1'b0;
    if (frame_err_d) begin
      break_pend_d = 1'b0;
    end else if (done) begin
      if (shreg_q == 8'hF0)  break_pend_d = 1'b1;
      else if (break_pend_q) break_pend_d = 1'b0;
      else                   present      = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) break_pend_q <= 1'b0;
    else         break_pend_q <= break_pend_d;
  end
`else
  assign present = done;
`endif

  assign accept = rx_valid_q & rx.rx_ready;

  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    overflow_d = overflow_q;
    if (accept) rx_valid_d = 1'b0;
    if (present) begin
      if (!rx_valid_q || accept) begin
        rx_data_d  = shreg_q;
        rx_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      par_ok_q    <= 1'b0;
      tmo_cnt_q   <= '0;
      frame_err_q <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      par_ok_q    <= par_ok_d;
      tmo_cnt_q   <= tmo_cnt_d;
      frame_err_q <= frame_err_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign rx.rx_data   = rx_data_q;
  assign rx.rx_valid  = rx_valid_q;
  assign rx.frame_err = frame_err_q;
  assign rx.overflow  = overflow_q;
  assign rx.busy      = (state_q != StIdle);

endmodule
